mtm_alu_serializer: RTL

MTM_ALU_SERIALIZER -- requirements
Module: mtm_alu_serializer

---
 rtl/mtm_alu_pkg.sv | 32 +++
 rtl/mtm_alu_frame_tx.sv | 68 ++++++
 rtl/mtm_alu_serializer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mtm_alu_pkg.sv
// -----------------------------------------------------------------------------
// mtm_alu_pkg
// Shared definitions for the MTM ALU serial output path: serializer state
// encoding, frame type bits, the OP-error control byte, frame geometry and a
// helper that assembles one 11-bit UART-like frame.
// No ports (package).
// -----------------------------------------------------------------------------
package mtm_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_NEXT_FRAME
    } ser_state_t;

    localparam logic FT_DATA = 1'b0;
    localparam logic FT_CTL  = 1'b1;

    // 1, ERR_OP code 001_001, even parity 1
    localparam logic [7:0] ERR_OP_BYTE = 8'h93;

    localparam int FRAME_LEN   = 11;
    localparam int DATA_FRAMES = 5;

    // Frame as shifted out MSB first: start(0), type, data[7:0], stop(1).
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic       ftype,
                                                         input logic [7:0] data);
        return {1'b0, ftype, data, 1'b1};
    endfunction

endpackage

// File: rtl/mtm_alu_frame_tx.sv
// -----------------------------------------------------------------------------
// mtm_alu_frame_tx
// Shifts one 11-bit frame out MSB first, each bit held CLKS_PER_BIT cycles.
// A load in the same cycle as done chains the next frame with no idle gap.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   load   - capture frame and start shifting on the next edge
//   frame  - frame to send (bit 10 leaves first)
//   sout   - serial output, 1 when no frame is active
//   done   - high during the last clock of the stop bit
// -----------------------------------------------------------------------------
module mtm_alu_frame_tx
    import mtm_alu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [FRAME_LEN-1:0] frame,
    output logic                 sout,
    output logic                 done
);

    localparam logic [7:0] TIMER_MAX = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_BIT  = 4'(FRAME_LEN - 1);

    logic [FRAME_LEN-1:0] shreg;
    logic [7:0]           timer;
    logic [3:0]           bit_cnt;
    logic                 active;
    logic                 bit_tick;

    assign bit_tick = (timer == TIMER_MAX);
    assign done     = active && bit_tick && (bit_cnt == LAST_BIT);
    assign sout     = active ? shreg[FRAME_LEN-1] : 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            timer   <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
        end else if (load) begin
            shreg   <= frame;
            timer   <= '0;
            bit_cnt <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (bit_tick) begin
                timer <= '0;
                if (bit_cnt == LAST_BIT) begin
                    active <= 1'b0;
                end else begin
                    shreg   <= {shreg[FRAME_LEN-2:0], 1'b1};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                timer <= timer + 8'd1;
            end
        end
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// -----------------------------------------------------------------------------
// mtm_alu_serializer
// Serializes ALU results as a 5-frame data packet (4 result bytes MSB first,
// then a control byte {0, flags, crc}). With MTM_SER_ERR_FRAME_EN defined,
// err_valid requests a single control frame carrying ERR_OP_BYTE; a request
// arriving while busy is held in a one-deep pending flag and sent right after
// the current packet.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   valid     - core result ready (level, held until ack_out)
//   result    - 32-bit ALU result, sampled on accept
//   flags     - {neg, zero, carry, overflow}, sampled on accept
//   crc       - core CRC3, sampled on accept
//   err_valid - single-cycle OP error packet request
//   ack_out   - one-cycle accept pulse to the core
//   sout      - serial line, idle high
//   busy      - packet in flight or pending
// -----------------------------------------------------------------------------
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] result,
    input  logic [3:0]  flags,
    input  logic [2:0]  crc,
    input  logic        err_valid,
    output logic        ack_out,
    output logic        sout,
    output logic        busy
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_FRAMES - 1);
    localparam logic [2:0] CTL_PREV = 3'(DATA_FRAMES - 2);

    ser_state_t           state, state_d;
    logic [31:0]          res_q;
    logic [7:0]           ctl_q;
    logic [2:0]           frame_idx, frame_idx_d;
    logic                 capture;
    logic                 tx_load;
    logic                 tx_done;
    logic [FRAME_LEN-1:0] tx_frame;
    logic [7:0]           nxt_byte;
    logic                 last_frame;

`ifdef MTM_SER_ERR_FRAME_EN
    logic pending, pending_d;
    logic pkt_err, pkt_err_d;

    assign last_frame = pkt_err || (frame_idx == LAST_IDX);
`else
    // Error path compiled out; the name keeps the dangling input lint-quiet.
    logic unused_err_valid;

    assign unused_err_valid = err_valid;
    assign last_frame       = (frame_idx == LAST_IDX);
`endif

    assign busy = (state != ST_IDLE);

    // Byte of the frame that follows frame_idx; byte 0 comes straight from
    // the input bus at capture so the start bit leaves without delay.
    always_comb begin
        case (frame_idx)
            3'd0:    nxt_byte = res_q[23:16];
            3'd1:    nxt_byte = res_q[15:8];
            3'd2:    nxt_byte = res_q[7:0];
            default: nxt_byte = ctl_q;
        endcase
    end

    // LOAD and NEXT_FRAME are entered on the edge that loads the frame
    // transmitter, so the line is already shifting while they are occupied.
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state;
        capture     = 1'b0;
        tx_load     = 1'b0;
        tx_frame    = build_frame(FT_DATA, result[31:24]);
        frame_idx_d = frame_idx;
`ifdef MTM_SER_ERR_FRAME_EN
        pending_d   = pending;
        pkt_err_d   = pkt_err;
        if (state != ST_IDLE && err_valid) begin
            pending_d = 1'b1;
        end
`endif
        case (state)
            ST_IDLE: begin
                if (valid) begin
                    capture     = 1'b1;
                    tx_load     = 1'b1;
                    frame_idx_d = '0;
                    state_d     = ST_LOAD;
`ifdef MTM_SER_ERR_FRAME_EN
                    pkt_err_d   = 1'b0;
                    if (err_valid) begin
                        pending_d = 1'b1;
                    end
`endif
                end
`ifdef MTM_SER_ERR_FRAME_EN
                else if (err_valid) begin
                    tx_load   = 1'b1;
                    tx_frame  = build_frame(FT_CTL, ERR_OP_BYTE);
                    pkt_err_d = 1'b1;
                    state_d   = ST_LOAD;
                end
`endif
            end
            ST_LOAD, ST_NEXT_FRAME: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tx_done) begin
                    if (!last_frame) begin
                        frame_idx_d = frame_idx + 3'd1;
                        tx_load     = 1'b1;
                        tx_frame    = build_frame((frame_idx == CTL_PREV) ? FT_CTL : FT_DATA,
                                                  nxt_byte);
                        state_d     = ST_NEXT_FRAME;
                    end
`ifdef MTM_SER_ERR_FRAME_EN
                    // A request landing on the final edge chains directly too.
                    else if (pending || err_valid) begin
                        tx_load   = 1'b1;
                        tx_frame  = build_frame(FT_CTL, ERR_OP_BYTE);
                        pkt_err_d = 1'b1;
                        pending_d = 1'b0;
                        state_d   = ST_NEXT_FRAME;
                    end
`endif
                    else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            res_q     <= '0;
            ctl_q     <= '0;
            frame_idx <= '0;
            ack_out   <= 1'b0;
`ifdef MTM_SER_ERR_FRAME_EN
            pending   <= 1'b0;
            pkt_err   <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            frame_idx <= frame_idx_d;
            ack_out   <= capture;
            if (capture) begin
                res_q <= result;
                ctl_q <= {1'b0, flags, crc};
            end
`ifdef MTM_SER_ERR_FRAME_EN
            pending   <= pending_d;
            pkt_err   <= pkt_err_d;
`endif
        end
    end

    mtm_alu_frame_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_frame_tx (
        .clk  (clk),
        .rst  (rst),
        .load (tx_load),
        .frame(tx_frame),
        .sout (sout),
        .done (tx_done)
    );

endmodule
